perceptron_sample_sequencer: RTL and testbench

// - Upstream feeder for the perceptron core: drives its values/expected/training inputs.
// - Training phase: replays the full truth table of a fixed boolean gate for EPOCHS passes.

---
 rtl/perceptron_sample_sequencer_pkg.sv | 30 +++
 rtl/perceptron_sample_sequencer_if.sv | 28 ++
 rtl/perceptron_sample_sequencer_debouncer.sv | 35 +++
 rtl/perceptron_sample_sequencer.sv | 131 +++++++++++++
 tb/tb_perceptron_sample_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_sample_sequencer_pkg.sv
// Shared types for the perceptron sample sequencer: fixed-point sample format,
// sequencer states and stock truth tables.
package perceptron_sample_sequencer_pkg;

    localparam int unsigned SFP_W           = 16;
    localparam int unsigned FRAC_W          = 8;
    localparam int unsigned GATE_W          = 16;
    localparam int unsigned GATE_IDX_W      = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 16;

    // Signed Q8.8 sample value
    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE = 16'sh0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        INFER = 2'd2
    } seq_state_e;

    // Bit k is the gate output for sample index k
    localparam logic [GATE_W-1:0] GATE_AND = 16'h0008;
    localparam logic [GATE_W-1:0] GATE_OR  = 16'h000E;

    function automatic sfp int_to_sfp(input int x);
        return SFP_W'(x <<< FRAC_W);
    endfunction

endpackage

// File: rtl/perceptron_sample_sequencer_if.sv
// Sample bus between the sequencer (master) and the perceptron core (slave).
interface perceptron_sample_sequencer_if
    import perceptron_sample_sequencer_pkg::*;
#(
    parameter int unsigned INPUT_UNITS = 2,
    parameter int unsigned EPOCHS      = 10
);
    localparam int unsigned EPOCH_W = $clog2(EPOCHS + 1);

    logic                   sample_ready;
    logic                   sample_valid;
    sfp [INPUT_UNITS-1:0]   values;
    sfp                     expected;
    logic                   training;
    logic [EPOCH_W-1:0]     epoch_count;
    logic                   done;

    modport master (
        input  sample_ready,
        output sample_valid, values, expected, training, epoch_count, done
    );

    modport slave (
        output sample_ready,
        input  sample_valid, values, expected, training, epoch_count, done
    );

endinterface

// File: rtl/perceptron_sample_sequencer_debouncer.sv
// Single-bit switch debouncer; only built when SEQUENCER_DEBOUNCE_EN is defined.
// Output follows the input after DEBOUNCE_CYCLES consecutive identical samples.
`ifdef SEQUENCER_DEBOUNCE_EN
module switch_debouncer
    import perceptron_sample_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             out_q;

    // Count consecutive samples that disagree with the current output
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (in_i == out_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            out_q <= in_i;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_o = out_q;

endmodule
`endif

// File: rtl/perceptron_sample_sequencer.sv
// Feeds the perceptron core: replays a gate truth table for EPOCHS passes, then
// streams synchronized switches. SEQUENCER_DEBOUNCE_EN adds per-switch debouncing.
module perceptron_sample_sequencer
    import perceptron_sample_sequencer_pkg::*;
#(
    parameter int unsigned       INPUT_UNITS = 2,
    parameter int unsigned       EPOCHS      = 10,
    parameter logic [GATE_W-1:0] GATE        = GATE_AND
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [INPUT_UNITS-1:0]  switch_in_i,
    perceptron_sample_sequencer_if.master seq_if
);
    localparam int unsigned IDX_W   = INPUT_UNITS;
    localparam int unsigned EPOCH_W = $clog2(EPOCHS + 1);

    typedef sfp [INPUT_UNITS-1:0] values_t;

    function automatic values_t train_values(input logic [IDX_W-1:0] idx);
        values_t v;
        v = '0;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            v[i] = idx[INPUT_UNITS-1-i] ? ONE : '0;
        end
        return v;
    endfunction

    function automatic sfp train_target(input logic [IDX_W-1:0] idx);
        return GATE[GATE_IDX_W'(idx)] ? ONE : '0;
    endfunction

    function automatic values_t switch_values(input logic [INPUT_UNITS-1:0] sw);
        values_t v;
        v = '0;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            v[i] = int_to_sfp(int'(sw[i]));
        end
        return v;
    endfunction

    seq_state_e             state_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [EPOCH_W-1:0]     epoch_q, epoch_d;
    values_t                values_q;
    sfp                     expected_q;
    logic                   valid_q, training_q, done_q;
    logic [INPUT_UNITS-1:0] sync1_q, sync2_q, sw_c;
    logic                   hs_c, wrap_c, last_c, restart_c;

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= switch_in_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef SEQUENCER_DEBOUNCE_EN
    for (genvar g = 0; g < INPUT_UNITS; g++) begin : g_deb
        switch_debouncer u_deb (
            .clk   (clk),
            .rst   (rst),
            .in_i  (sync2_q[g]),
            .out_o (sw_c[g])
        );
    end
`else
    assign sw_c = sync2_q;
`endif

    // Sample index / epoch advance on each accepted training sample
    always_comb begin
        hs_c    = (state_q == TRAIN) && valid_q && seq_if.sample_ready;
        wrap_c  = hs_c && (idx_q == IDX_W'((1 << INPUT_UNITS) - 1));
        last_c  = wrap_c && (epoch_q == EPOCH_W'(EPOCHS - 1));
        idx_d   = hs_c ? idx_q + IDX_W'(1) : idx_q;
        epoch_d = (wrap_c && (epoch_q != EPOCH_W'(EPOCHS))) ? epoch_q + EPOCH_W'(1) : epoch_q;
        // start only matters outside TRAIN, or when it collides with the final handshake
        restart_c = start_i && ((state_q != TRAIN) || last_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            epoch_q    <= '0;
            values_q   <= '0;
            expected_q <= '0;
            valid_q    <= 1'b0;
            training_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (restart_c) begin
            state_q    <= TRAIN;
            idx_q      <= '0;
            epoch_q    <= '0;
            values_q   <= train_values(IDX_W'(0));
            expected_q <= train_target(IDX_W'(0));
            valid_q    <= 1'b1;
            training_q <= 1'b1;
            done_q     <= 1'b0;
        end else if (last_c) begin
            state_q    <= INFER;
            idx_q      <= '0;
            epoch_q    <= epoch_d;
            values_q   <= switch_values(sw_c);
            expected_q <= '0;
            training_q <= 1'b0;
            done_q     <= 1'b1;
        end else if (state_q == TRAIN) begin
            idx_q      <= idx_d;
            epoch_q    <= epoch_d;
            values_q   <= train_values(idx_d);
            expected_q <= train_target(idx_d);
        end else if (state_q == INFER) begin
            values_q   <= switch_values(sw_c);
        end
    end

    assign seq_if.sample_valid = valid_q;
    assign seq_if.values       = values_q;
    assign seq_if.expected     = expected_q;
    assign seq_if.training     = training_q;
    assign seq_if.epoch_count  = epoch_q;
    assign seq_if.done         = done_q;

endmodule

// File: tb/tb_perceptron_sample_sequencer.sv
// Scoreboard bench for perceptron_sample_sequencer (AND gate) plus an OR-gate instance.
module tb_perceptron_sample_sequencer;
    import perceptron_sample_sequencer_pkg::*;

    localparam int unsigned IU  = 2;
    localparam int unsigned EP  = 10;
    localparam int unsigned NS  = 4;
    localparam logic [15:0] V1  = 16'h0100;
    localparam logic [3:0]  TT_AND = 4'b1000;
`ifdef SEQUENCER_DEBOUNCE_EN
    localparam int unsigned LAT = 19;
    localparam bit          DEB = 1'b1;
`else
    localparam int unsigned LAT = 3;
    localparam bit          DEB = 1'b0;
`endif

    typedef struct packed {
        logic [IU*16-1:0] values;
        logic [15:0]      expected;
        logic             valid;
        logic             training;
        logic             done;
        logic [3:0]       epoch;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IU-1:0] sw = '0;
    logic [IU-1:0] sw_zero = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    perceptron_sample_sequencer_if #(.INPUT_UNITS(IU), .EPOCHS(EP)) seq_if ();
    perceptron_sample_sequencer_if #(.INPUT_UNITS(IU), .EPOCHS(EP)) or_if ();

    perceptron_sample_sequencer #(.INPUT_UNITS(IU), .EPOCHS(EP), .GATE(GATE_AND)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .switch_in_i (sw),
        .seq_if      (seq_if.master)
    );

    perceptron_sample_sequencer #(.INPUT_UNITS(IU), .EPOCHS(EP), .GATE(GATE_OR)) dut_or (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .switch_in_i (sw_zero),
        .seq_if      (or_if.master)
    );

    assign or_if.sample_ready = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Reference: sample number n within the current run, idx = n % NS, epoch = n / NS
    function automatic obs_t make_obs(input int st, input int n, input logic [IU-1:0] swv);
        obs_t o;
        int   idx;
        o   = '0;
        idx = n % NS;
        if (st == 1) begin
            for (int i = 0; i < IU; i++)
                o.values[i*16 +: 16] = (((idx >> (IU-1-i)) & 1) != 0) ? V1 : 16'h0;
            o.expected = TT_AND[idx] ? V1 : 16'h0;
            o.valid    = 1'b1;
            o.training = 1'b1;
            o.epoch    = 4'(n / NS);
        end else if (st == 2) begin
            for (int i = 0; i < IU; i++)
                o.values[i*16 +: 16] = swv[i] ? V1 : 16'h0;
            o.valid = 1'b1;
            o.done  = 1'b1;
            o.epoch = 4'(EP);
        end
        return o;
    endfunction

    obs_t          sb_q[$];
    int            m_state = 0;
    int            m_n = 0;
    logic [IU-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
    int            m_run[IU];

    // Model step: predict the outputs that appear after this edge
    always @(posedge clk) begin
        logic [IU-1:0] swe;
        swe = DEB ? m_deb : m_s2;
        if (rst) begin
            m_state = 0; m_n = 0; m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < IU; i++) m_run[i] = 0;
            swe = '0;
        end else begin
            case (m_state)
                0: if (start) begin m_state = 1; m_n = 0; end
                1: if (seq_if.sample_ready) begin
                       m_n++;
                       if (m_n == NS*EP) begin
                           if (start) m_n = 0;
                           else m_state = 2;
                       end
                   end
                default: if (start) begin m_state = 1; m_n = 0; end
            endcase
            for (int i = 0; i < IU; i++) begin
                m_run[i] = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == 16) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
        sb_q.push_back(make_obs(m_state, m_n, swe));
    end

    always @(negedge clk) begin
        obs_t e;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_underflow t=%0t got=empty expected=entry", $time);
        end else begin
            e = sb_q.pop_front();
            check_eq("values",   64'(seq_if.values), 64'(e.values));
            check_eq("expected", 64'($unsigned(seq_if.expected)), 64'(e.expected));
            check_eq("valid",    64'(seq_if.sample_valid), 64'(e.valid));
            check_eq("training", 64'(seq_if.training), 64'(e.training));
            check_eq("done",     64'(seq_if.done), 64'(e.done));
            check_eq("epoch",    64'(seq_if.epoch_count), 64'(e.epoch));
        end
    end

    task automatic wait_done(input string tag);
        int cnt = 0;
        while (!seq_if.done && cnt < 200) begin @(negedge clk); cnt++; end
        check_eq(tag, 64'(seq_if.done), 64'(1));
    endtask

    task automatic wait_sample(input string tag, input int ep, input logic [31:0] v);
        int cnt = 0;
        while (!(seq_if.epoch_count == 4'(ep) && seq_if.values == v) && cnt < 200) begin
            @(negedge clk); cnt++;
        end
        check_eq(tag, 64'(seq_if.values), 64'(v));
    endtask

    initial begin
        seq_if.sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_valid", 64'(seq_if.sample_valid), 64'(0));

        // Full training run, OR instance checked over two epochs
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("or_expected", 64'($unsigned(or_if.expected)), ((k % 4) != 0) ? 64'(V1) : 64'(0));
            @(negedge clk);
        end
        wait_done("train_done");
        check_eq("done_training", 64'(seq_if.training), 64'(0));
        check_eq("done_epochs",   64'(seq_if.epoch_count), 64'(EP));

        // Restart from INFER, then backpressure at idx=2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        seq_if.sample_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_hold", 64'(seq_if.values), 64'(32'h0000_0100));
        end
        seq_if.sample_ready = 1'b1;

        // start coincident with the final handshake
        wait_sample("reach_last", 9, 32'h0100_0100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("collide_done",  64'(seq_if.done), 64'(0));
        check_eq("collide_epoch", 64'(seq_if.epoch_count), 64'(0));
        check_eq("collide_train", 64'(seq_if.training), 64'(1));

        // Reset mid-run at idx=3, epoch 4
        wait_sample("reach_e4", 4, 32'h0100_0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", 64'(seq_if.sample_valid), 64'(0));
        check_eq("rst_epoch", 64'(seq_if.epoch_count), 64'(0));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("replay_vals", 64'(seq_if.values), 64'(0));
        check_eq("replay_valid", 64'(seq_if.sample_valid), 64'(1));

        // Inference latency, random ready which must be ignored
        wait_done("infer_done");
        repeat (3) @(negedge clk);
        sw = 2'b10;
        for (int k = 1; k <= int'(LAT); k++) begin
            seq_if.sample_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k == int'(LAT) - 1) check_eq("lat_before", 64'(seq_if.values), 64'(0));
            if (k == int'(LAT))     check_eq("lat_exact", 64'(seq_if.values), 64'(32'h0100_0000));
        end

        // Short glitch, then random switch activity
        sw = 2'b11;
        repeat (5) @(negedge clk);
        sw = 2'b10;
        repeat (LAT + 4) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            sw = IU'($urandom_range(0, 3));
            repeat ($urandom_range(1, 24)) @(negedge clk);
        end
        repeat (LAT + 2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
